// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - fetch FSM state encoding and instruction field positions
package fetch_pkg;

    typedef enum logic [2:0] {
        REQ  = 3'd0,
        WAIT = 3'd1,
        LOAD = 3'd2,
        HOLD = 3'd3,
        TRAP = 3'd4
    } fetchState_t;

    localparam int OPC_HI   = 31;
    localparam int OPC_LO   = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int IMM_HI   = 15;
    localparam int IMM_LO   = 0;
    localparam int FUNCT_HI = 5;
    localparam int FUNCT_LO = 0;

endpackage

// File: rtl/fetch_ir.sv
// rtl/fetch_ir.sv - load-enabled instruction register with field slicing
module fetch_ir
    import fetch_pkg::*;
#(
    parameter int INSTR_W = 32
) (
    input  logic               clock,
    input  logic               res,
    input  logic               loadEn,
    input  logic [INSTR_W-1:0] loadData,
    output logic [INSTR_W-1:0] instr,
    output logic [5:0]         opcode,
    output logic [4:0]         rs,
    output logic [4:0]         rt,
    output logic [15:0]        imm,
    output logic [5:0]         funct
);

    logic [INSTR_W-1:0] irReg;

    always_ff @(posedge clock) begin
        if (res) begin
            irReg <= '0;
        end else if (loadEn) begin
            irReg <= loadData;
        end
    end

    assign instr  = irReg;
    assign opcode = irReg[OPC_HI:OPC_LO];
    assign rs     = irReg[RS_HI:RS_LO];
    assign rt     = irReg[RT_HI:RT_LO];
    assign imm    = irReg[IMM_HI:IMM_LO];
    assign funct  = irReg[FUNCT_HI:FUNCT_LO];

endmodule

// File: rtl/multicycle_fetch_unit.sv
// rtl/multicycle_fetch_unit.sv - PC, latency-tolerant fetch FSM and IR handshake
// Optional misaligned-redirect trap: FETCH_MISALIGN_TRAP_EN
module multicycle_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                INSTR_W     = 32,
    parameter int                MEM_LATENCY = 1,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int                PC_STEP     = 4
) (
    input  logic               clock,
    input  logic               res,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_rd,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [5:0]         opcode,
    output logic [4:0]         rs,
    output logic [4:0]         rt,
    output logic [15:0]        imm,
    output logic [5:0]         funct,
    output logic [ADDR_W-1:0]  pc,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic               fetch_trap,
`endif
    output logic [2:0]         state
);

    localparam int CNT_W = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((MEM_LATENCY > 1) ? MEM_LATENCY - 2 : 0);

    fetchState_t       curState, nextState;
    logic [ADDR_W-1:0] pcReg, nextPc;
    logic [CNT_W-1:0]  waitCnt;
    logic              irLoad;

    always_ff @(posedge clock) begin
        if (res) begin
            curState <= REQ;
            pcReg    <= RESET_PC;
            waitCnt  <= '0;
        end else begin
            curState <= nextState;
            pcReg    <= nextPc;
            waitCnt  <= (curState == WAIT && nextState == WAIT) ? waitCnt + 1'b1 : '0;
        end
    end

    always_comb begin
        nextState = curState;
        nextPc    = pcReg;
        irLoad    = 1'b0;
        case (curState)
            REQ:  nextState = (MEM_LATENCY == 1) ? LOAD : WAIT;
            WAIT: if (waitCnt == WAIT_LAST) nextState = LOAD;
            LOAD: begin
                nextState = HOLD;
                irLoad    = 1'b1;
            end
            HOLD: if (instr_ready) begin
                nextState = REQ;
                nextPc    = pcReg + ADDR_W'(PC_STEP);
            end
            TRAP: nextState = TRAP;
            default: nextState = REQ;
        endcase
        // A redirect beats every in-flight action, including the HOLD handoff and the IR load.
        if (redirect_valid && curState != TRAP) begin
            irLoad = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            nextPc    = redirect_pc;
            nextState = (redirect_pc[1:0] != 2'b00) ? TRAP : REQ;
`else
            nextPc    = redirect_pc & ~ADDR_W'(3);
            nextState = REQ;
`endif
        end
    end

    fetch_ir #(.INSTR_W(INSTR_W)) u_ir (
        .clock   (clock),
        .res     (res),
        .loadEn  (irLoad),
        .loadData(mem_rdata),
        .instr   (instr),
        .opcode  (opcode),
        .rs      (rs),
        .rt      (rt),
        .imm     (imm),
        .funct   (funct)
    );

    assign mem_addr    = pcReg;
    assign mem_rd      = !res && (curState == REQ || curState == WAIT || curState == LOAD);
    assign instr_valid = (curState == HOLD);
    assign pc          = pcReg;
    assign state       = curState;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign fetch_trap  = (curState == TRAP);
`endif

endmodule
